// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: byte width, buffer depth and header field layout.
package router_pkg;

    localparam int DATA_W       = 8;
    localparam int FIFO_DEPTH   = 16;
    localparam int FIFO_ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int PKT_CNT_W    = 7;

    // Header byte: [7:2] payload length, [1:0] destination address.
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    // The stored word carries the header tag just above the payload byte.
    localparam int TAG_BIT      = DATA_W;

endpackage

// File: rtl/router_fifo_mem.sv
// Register array behind router_fifo: one synchronous write port, one combinational read port.
module router_fifo_mem #(
    parameter int WORD_W = 9,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // No reset: contents are only ever read behind a valid pointer.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output buffer: tagged byte FIFO with a read-side packet counter.
module router_fifo #(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = router_pkg::FIFO_DEPTH,
    parameter int ADDR_W = router_pkg::FIFO_ADDR_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] data_out
);

    import router_pkg::*;

    localparam int WORD_W = DATA_W + 1;

    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;

    logic               wr_accept;
    logic               rd_accept;
    logic [WORD_W-1:0]  wr_word;
    logic [WORD_W-1:0]  rd_word;
    logic [PKT_CNT_W-1:0] hdr_cnt;

    // Wrap bit differs with equal index bits only when every slot is occupied.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    assign wr_accept = write_enb && !full && !soft_reset;
    assign rd_accept = read_enb && !empty && !soft_reset;
    assign wr_word   = {lfd_state, data_in};

    router_fifo_mem #(
        .WORD_W(WORD_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clock(clock),
        .we   (wr_accept),
        .waddr(wr_ptr_q[ADDR_W-1:0]),
        .wdata(wr_word),
        .raddr(rd_ptr_q[ADDR_W-1:0]),
        .rdata(rd_word)
    );

    // A header reload counts the payload bytes plus the trailing parity byte.
    assign hdr_cnt = PKT_CNT_W'(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;

        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                data_out_d = rd_word[DATA_W-1:0];
                if (rd_word[DATA_W]) begin
                    pkt_cnt_d = hdr_cnt;
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q - 1'b1;
                end
            end else if (pkt_cnt_q == '0) begin
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule
